align_job_scheduler: RTL and testbench
======================================

// Module: align_job_scheduler
// PURPOSE
// - Shares one local-alignment accelerator between NUM_REQ requesters. Round-robin grant, latch the
//   query/database pair, issue start, stream 8 load chunks, then forward traceback beats tagged with owner ID.
// - Sits between host-side requesters and the accelerator top (start/ready/output_valid/finished handshake).
// PARAMETERS
// - NUM_REQ      4    number of requesters
// - REQ_ID_W     2    $clog2(NUM_REQ), derived
// - SEQ_BITS     64   32 letters x 2 bits per sequence
// - CHUNK_W      8    bits per sequence per load cycle; NUM_CHUNKS = SEQ_BITS/CHUNK_W = 8
// - ROW_W/COL_W  5    traceback coordinate widths
// - WDOG_CYCLES  256  watchdog limit, used only with ALIGN_SCHED_WDOG_EN
// PORTS
// - clk           in   1               clock
// - rst_n         in   1               reset, asynchronous, active-low
// - req_valid     in   NUM_REQ         per-requester job request; data held stable until grant
// - req_query     in   NUM_REQ*SEQ_BITS  per-requester query sequence
// - req_db        in   NUM_REQ*SEQ_BITS  per-requester database sequence
// - req_grant     out  NUM_REQ         one-hot, single-cycle pulse; job accepted, data latched
// - accel_ready   in   1               accelerator idle
// - accel_start   out  1               single-cycle start pulse
// - accel_q_chunk out  CHUNK_W         query chunk k, LSB chunk first
// - accel_d_chunk out  CHUNK_W         database chunk k
// - accel_out_vld in   1               traceback beat valid
// - accel_row     in   ROW_W           traceback row
// - accel_col     in   COL_W           traceback column
// - accel_finished in  1               last traceback beat
// - rsp_valid     out  1               response beat valid (no backpressure)
// - rsp_id        out  REQ_ID_W        owning requester
// - rsp_row/rsp_col out ROW_W/COL_W    forwarded coordinate
// - rsp_last      out  1               final beat of job
// - rsp_error     out  1               job aborted (watchdog only; tied 0 otherwise)
// - busy          out  1               a job is owned
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, rr pointer 0, latched sequences 0.
// - FSM: IDLE -> START -> LOAD -> CALC -> TRACE -> IDLE.
// - IDLE: if any req_valid, rr pick (search starts at ptr); req_grant pulses same cycle, latch query/db and ID,
//   ptr <= winner+1 mod NUM_REQ; -> START. No req_valid: stay. Requester dropping valid before grant is ignored.
// - START: hold until accel_ready=1; in that cycle accel_start=1; -> LOAD with chunk counter 0.
// - LOAD: 8 cycles; cycle k drives chunk k = bits [k*8+:8] of latched query/db; after k=7 -> CALC.
// - CALC: wait for accel_out_vld; the same cycle is treated as the first TRACE beat (-> TRACE).
// - TRACE/CALC beat: rsp_* registered from accel_* with 1-cycle latency; rsp_id = owner ID;
//   rsp_last = accel_finished. Beat with accel_finished -> IDLE; new grant possible the cycle after.
// - accel_finished with accel_out_vld=0: still ends the job, emits rsp_valid=1, rsp_last=1 with row/col 0.
// - Simultaneous requests: exactly one grant per job; a requester granted last round has lowest priority.
// - busy = (state != IDLE). rsp_valid is 0 outside CALC/TRACE beats; no grant while busy.
// - Reset mid-job: immediate return to IDLE, no rsp_last emitted; requester must re-request.
// CONFIGURATION
// - ALIGN_SCHED_WDOG_EN defined: cycle counter cleared on accel_start, counts in LOAD/CALC/TRACE; on reaching
//   WDOG_CYCLES-1 without accel_finished emit one beat rsp_valid=1, rsp_last=1, rsp_error=1, -> IDLE;
//   later accelerator beats are dropped until accel_ready=1.
// - Undefined: no counter, rsp_error tied 0, job waits indefinitely.
// STRUCTURE
// - design_variables package: scheduler state enum, NUM_REQ, CHUNK_W, NUM_CHUNKS, WDOG_CYCLES.
// - Sub-module rr_arbiter (NUM_REQ): req vector + ptr in -> one-hot grant + encoded ID.
// - Top holds FSM, chunk counter, sequence latches, response register, optional watchdog.
// TESTING
// - Single job req0, query=64'h0123_4567_89AB_CDEF -> grant[0] 1 cycle, start once, chunks EF,CD,AB,89,67,45,23,01.
// - req_valid=4'b1111 held, 4 jobs -> grants in order 0,1,2,3; then 4'b1001 -> grant 0 next.
// - 5-beat traceback (row,col)=(12,9)..(8,5), finished on beat 5 -> 5 rsp beats 1 cycle later, rsp_last on 5th only, rsp_id correct.
// - accel_ready=0 for 10 cycles in START -> accel_start held off, fires the first cycle ready=1.
// - rst_n low during LOAD chunk 3 -> all outputs 0 next, no rsp_last; fresh req accepted after release.
// - ALIGN_SCHED_WDOG_EN, WDOG_CYCLES=256, no finished -> rsp_valid+rsp_last+rsp_error 256 cycles after start.

Source files
------------

// File: rtl/align_job_scheduler_pkg.sv
// Shared types and sizing for the alignment job scheduler.
// Optional watchdog is enabled by defining ALIGN_SCHED_WDOG_EN.
package align_job_scheduler_pkg;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned REQ_ID_W    = $clog2(NUM_REQ);
  localparam int unsigned SEQ_BITS    = 64;
  localparam int unsigned CHUNK_W     = 8;
  localparam int unsigned NUM_CHUNKS  = SEQ_BITS / CHUNK_W;
  localparam int unsigned CHUNK_CNT_W = $clog2(NUM_CHUNKS);
  localparam int unsigned ROW_W       = 5;
  localparam int unsigned COL_W       = 5;
  localparam int unsigned WDOG_CYCLES = 256;
  localparam int unsigned WDOG_W      = $clog2(WDOG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_CALC,
    S_TRACE
  } sched_state_e;

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic                last;
    logic                error;
  } rsp_beat_t;

  // Round-robin pointer advance: the requester after the winner gets first look next time.
  function automatic logic [REQ_ID_W-1:0] next_ptr(input logic [REQ_ID_W-1:0] id);
    return REQ_ID_W'((32'(id) + 32'd1) % NUM_REQ);
  endfunction

endpackage

// File: rtl/align_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
module align_job_scheduler_rr_arbiter
  import align_job_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [REQ_ID_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_c,
  output logic [REQ_ID_W-1:0] id_c,
  output logic                any_c
);

  logic [REQ_ID_W-1:0] idx;

  always_comb begin
    grant_c = '0;
    id_c    = '0;
    any_c   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = REQ_ID_W'((32'(ptr_i) + i) % NUM_REQ);
      if (!any_c && req_i[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        id_c         = idx;
      end
    end
  end

endmodule

// File: rtl/align_job_scheduler.sv
// Shares one alignment accelerator between NUM_REQ requesters and tags traceback beats with the owner.
// Define ALIGN_SCHED_WDOG_EN to add a watchdog that aborts a stuck job with rsp_error.
module align_job_scheduler
  import align_job_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*SEQ_BITS-1:0]  req_query,
  input  logic [NUM_REQ*SEQ_BITS-1:0]  req_db,
  output logic [NUM_REQ-1:0]           req_grant,
  input  logic                         accel_ready,
  output logic                         accel_start,
  output logic [CHUNK_W-1:0]           accel_q_chunk,
  output logic [CHUNK_W-1:0]           accel_d_chunk,
  input  logic                         accel_out_vld,
  input  logic [ROW_W-1:0]             accel_row,
  input  logic [COL_W-1:0]             accel_col,
  input  logic                         accel_finished,
  output logic                         rsp_valid,
  output logic [REQ_ID_W-1:0]          rsp_id,
  output logic [ROW_W-1:0]             rsp_row,
  output logic [COL_W-1:0]             rsp_col,
  output logic                         rsp_last,
  output logic                         rsp_error,
  output logic                         busy
);

  sched_state_e             state_q;
  logic [REQ_ID_W-1:0]      ptr_q;
  logic [REQ_ID_W-1:0]      owner_q;
  logic [SEQ_BITS-1:0]      q_lat_q;
  logic [SEQ_BITS-1:0]      d_lat_q;
  logic [CHUNK_CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0]       grant_q;
  logic                     start_q;
  logic [CHUNK_W-1:0]       q_chunk_q;
  logic [CHUNK_W-1:0]       d_chunk_q;
  logic                     rsp_valid_q;
  rsp_beat_t                rsp_q;
  logic                     busy_q;
`ifdef ALIGN_SCHED_WDOG_EN
  logic [WDOG_W-1:0]        wdog_q;
`endif

  logic [SEQ_BITS-1:0]      query_arr [NUM_REQ];
  logic [SEQ_BITS-1:0]      db_arr    [NUM_REQ];
  logic [NUM_REQ-1:0]       arb_grant;
  logic [REQ_ID_W-1:0]      arb_id;
  logic                     arb_any;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign query_arr[g] = req_query[g*SEQ_BITS +: SEQ_BITS];
    assign db_arr[g]    = req_db[g*SEQ_BITS +: SEQ_BITS];
  end

  align_job_scheduler_rr_arbiter u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_c (arb_grant),
    .id_c    (arb_id),
    .any_c   (arb_any)
  );

  // Job FSM; sequence latches shift right so chunk 0 is always the low byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      q_lat_q     <= '0;
      d_lat_q     <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      q_chunk_q   <= '0;
      d_chunk_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      busy_q      <= 1'b0;
`ifdef ALIGN_SCHED_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      grant_q     <= '0;
      start_q     <= 1'b0;
      q_chunk_q   <= '0;
      d_chunk_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
`ifdef ALIGN_SCHED_WDOG_EN
      if (state_q inside {S_LOAD, S_CALC, S_TRACE}) wdog_q <= wdog_q + WDOG_W'(1);
`endif
      case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            owner_q <= arb_id;
            q_lat_q <= query_arr[arb_id];
            d_lat_q <= db_arr[arb_id];
            ptr_q   <= next_ptr(arb_id);
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (accel_ready) begin
            start_q <= 1'b1;
            cnt_q   <= '0;
`ifdef ALIGN_SCHED_WDOG_EN
            wdog_q  <= '0;
`endif
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          q_chunk_q <= q_lat_q[CHUNK_W-1:0];
          d_chunk_q <= d_lat_q[CHUNK_W-1:0];
          q_lat_q   <= q_lat_q >> CHUNK_W;
          d_lat_q   <= d_lat_q >> CHUNK_W;
          cnt_q     <= cnt_q + CHUNK_CNT_W'(1);
          if (cnt_q == CHUNK_CNT_W'(NUM_CHUNKS - 1)) state_q <= S_CALC;
        end
        S_CALC, S_TRACE: begin
          // A bare finished still closes the job, with zeroed coordinates.
          if (accel_finished) begin
            rsp_valid_q <= 1'b1;
            rsp_q <= '{id: owner_q,
                       row: accel_out_vld ? accel_row : '0,
                       col: accel_out_vld ? accel_col : '0,
                       last: 1'b1, error: 1'b0};
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef ALIGN_SCHED_WDOG_EN
          else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_q <= '{id: owner_q, row: '0, col: '0, last: 1'b1, error: 1'b1};
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`endif
          else if (accel_out_vld) begin
            rsp_valid_q <= 1'b1;
            rsp_q <= '{id: owner_q, row: accel_row, col: accel_col,
                       last: 1'b0, error: 1'b0};
            state_q <= S_TRACE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_grant     = grant_q;
  assign accel_start   = start_q;
  assign accel_q_chunk = q_chunk_q;
  assign accel_d_chunk = d_chunk_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_q.id;
  assign rsp_row       = rsp_q.row;
  assign rsp_col       = rsp_q.col;
  assign rsp_last      = rsp_q.last;
  assign rsp_error     = rsp_q.error;
  assign busy          = busy_q;

endmodule

// File: tb/tb_align_job_scheduler.sv
// Directed bench for align_job_scheduler: arbitration, chunk streaming, traceback forwarding, reset.
module tb_align_job_scheduler;
  import align_job_scheduler_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*SEQ_BITS-1:0] req_query;
  logic [NUM_REQ*SEQ_BITS-1:0] req_db;
  logic [NUM_REQ-1:0]          req_grant;
  logic                        accel_ready;
  logic                        accel_start;
  logic [CHUNK_W-1:0]          accel_q_chunk;
  logic [CHUNK_W-1:0]          accel_d_chunk;
  logic                        accel_out_vld;
  logic [ROW_W-1:0]            accel_row;
  logic [COL_W-1:0]            accel_col;
  logic                        accel_finished;
  logic                        rsp_valid;
  logic [REQ_ID_W-1:0]         rsp_id;
  logic [ROW_W-1:0]            rsp_row;
  logic [COL_W-1:0]            rsp_col;
  logic                        rsp_last;
  logic                        rsp_error;
  logic                        busy;

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] q0 = 64'h0123_4567_89AB_CDEF;
  logic [63:0] d0 = 64'hFEDC_BA98_7654_3210;
  logic [63:0] q3 = 64'hA5A5_5A5A_1122_3344;
  logic [63:0] d3 = 64'h0F1E_2D3C_4B5A_6978;

  always #5 clk = ~clk;

  align_job_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_query(req_query), .req_db(req_db), .req_grant(req_grant),
    .accel_ready(accel_ready), .accel_start(accel_start),
    .accel_q_chunk(accel_q_chunk), .accel_d_chunk(accel_d_chunk),
    .accel_out_vld(accel_out_vld), .accel_row(accel_row), .accel_col(accel_col),
    .accel_finished(accel_finished),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_row(rsp_row), .rsp_col(rsp_col),
    .rsp_last(rsp_last), .rsp_error(rsp_error), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NUM_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (req_grant !== '0) begin
        g = req_grant;
        break;
      end
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (accel_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the cycle start is seen: run out the load, then close with one finished beat.
  task automatic finish_job();
    repeat (8) tick();
    accel_out_vld = 1'b1; accel_finished = 1'b1; accel_row = 5'd1; accel_col = 5'd2;
    tick();
    accel_out_vld = 1'b0; accel_finished = 1'b0; accel_row = '0; accel_col = '0;
  endtask

  task automatic test_reset();
    logic [36:0] obs;
    req_valid = '0; accel_ready = 1'b1; accel_out_vld = 1'b0; accel_finished = 1'b0;
    accel_row = '0; accel_col = '0;
    req_query = {q3, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, q0};
    req_db    = {d3, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000, d0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {req_grant, accel_start, accel_q_chunk, accel_d_chunk, rsp_valid, rsp_id,
           rsp_row, rsp_col, rsp_last, rsp_error, busy};
    n_total++;
    if (obs !== 37'd0) $display("FAIL reset_outputs got=%h exp=0", obs);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] g;
    logic [NUM_REQ-1:0] exp;
    bit ok;
    req_valid = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g);
      exp = 4'(1 << j);
      n_total++;
      if (g !== exp) $display("FAIL rr_grant_%0d got=%b exp=%b", j, g, exp);
      else n_pass++;
      wait_start(ok);
      finish_job();
    end
    req_valid = 4'b1001;
    wait_grant(g);
    n_total++;
    if (g !== 4'b0001) $display("FAIL rr_after_3 got=%b exp=0001", g);
    else n_pass++;
    req_valid = '0;
    wait_start(ok);
    finish_job();
  endtask

  task automatic test_single_job();
    logic [16:0] obs;
    logic [16:0] exp;
    logic [14:0] robs;
    req_valid = 4'b0001;
    tick();
    n_total++;
    if ({req_grant, busy, accel_start} !== {4'b0001, 1'b1, 1'b0})
      $display("FAIL single_grant got grant=%b busy=%b start=%b exp 0001/1/0", req_grant, busy, accel_start);
    else n_pass++;
    req_valid = '0;
    tick();
    n_total++;
    if ({req_grant, accel_start} !== {4'b0000, 1'b1})
      $display("FAIL single_start got grant=%b start=%b exp 0000/1", req_grant, accel_start);
    else n_pass++;
    for (int k = 0; k < 8; k++) begin
      tick();
      obs = {accel_start, accel_q_chunk, accel_d_chunk};
      exp = {1'b0, q0[k*8 +: 8], d0[k*8 +: 8]};
      n_total++;
      if (obs !== exp) $display("FAIL chunk_%0d got=%h exp=%h", k, obs, exp);
      else n_pass++;
    end
    accel_out_vld = 1'b1; accel_finished = 1'b1; accel_row = 5'd3; accel_col = 5'd4;
    tick();
    accel_out_vld = 1'b0; accel_finished = 1'b0; accel_row = '0; accel_col = '0;
    robs = {rsp_valid, rsp_id, rsp_row, rsp_col, rsp_last, rsp_error};
    n_total++;
    if (robs !== {1'b1, 2'd0, 5'd3, 5'd4, 1'b1, 1'b0})
      $display("FAIL single_rsp got=%h exp=%h", robs, {1'b1, 2'd0, 5'd3, 5'd4, 1'b1, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle got valid=%b busy=%b exp 0/0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_trace_beats();
    logic [NUM_REQ-1:0] g;
    logic [14:0] robs;
    logic [14:0] rexp;
    bit ok;
    req_valid = 4'b0100;
    wait_grant(g);
    req_valid = '0;
    n_total++;
    if (g !== 4'b0100) $display("FAIL trace_grant got=%b exp=0100", g);
    else n_pass++;
    wait_start(ok);
    repeat (8) tick();
    tick();
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL calc_quiet got=%b exp=0", rsp_valid);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      accel_out_vld = 1'b1;
      accel_row = 5'(12 - i);
      accel_col = 5'(9 - i);
      accel_finished = (i == 4);
      tick();
      robs = {rsp_valid, rsp_id, rsp_row, rsp_col, rsp_last, rsp_error};
      rexp = {1'b1, 2'd2, 5'(12 - i), 5'(9 - i), (i == 4), 1'b0};
      n_total++;
      if (robs !== rexp) $display("FAIL trace_beat_%0d got=%h exp=%h", i, robs, rexp);
      else n_pass++;
    end
    accel_out_vld = 1'b0; accel_finished = 1'b0; accel_row = '0; accel_col = '0;
    tick();
    n_total++;
    if ({rsp_valid, busy} !== 2'b00) $display("FAIL trace_end got valid=%b busy=%b exp 0/0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_start_holdoff();
    logic [NUM_REQ-1:0] g;
    bit early;
    accel_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = '0;
    n_total++;
    if (g !== 4'b0010) $display("FAIL holdoff_grant got=%b exp=0010", g);
    else n_pass++;
    early = 1'b0;
    repeat (10) begin
      tick();
      if (accel_start !== 1'b0) early = 1'b1;
    end
    n_total++;
    if (early !== 1'b0) $display("FAIL holdoff_quiet got=%b exp=0", early);
    else n_pass++;
    accel_ready = 1'b1;
    tick();
    n_total++;
    if (accel_start !== 1'b1) $display("FAIL holdoff_fire got=%b exp=1", accel_start);
    else n_pass++;
    finish_job();
  endtask

  task automatic test_reset_mid_job();
    logic [NUM_REQ-1:0] g;
    logic [36:0] obs;
    bit ok;
    bit saw_last;
    req_valid = 4'b1000;
    wait_grant(g);
    req_valid = '0;
    wait_start(ok);
    repeat (4) tick();
    n_total++;
    if ({accel_q_chunk, accel_d_chunk, busy} !== {8'h11, 8'h4B, 1'b1})
      $display("FAIL mid_chunk3 got q=%h d=%h busy=%b exp 11/4b/1", accel_q_chunk, accel_d_chunk, busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    obs = {req_grant, accel_start, accel_q_chunk, accel_d_chunk, rsp_valid, rsp_id,
           rsp_row, rsp_col, rsp_last, rsp_error, busy};
    n_total++;
    if (obs !== 37'd0) $display("FAIL mid_reset_outputs got=%h exp=0", obs);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    saw_last = 1'b0;
    repeat (3) begin
      tick();
      if (rsp_last !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) saw_last = 1'b1;
    end
    n_total++;
    if (saw_last !== 1'b0) $display("FAIL mid_no_last got=%b exp=0", saw_last);
    else n_pass++;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    n_total++;
    if (req_grant !== 4'b0001) $display("FAIL mid_regrant got=%b exp=0001", req_grant);
    else n_pass++;
    wait_start(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL mid_restart got=%b exp=1", ok);
    else n_pass++;
    finish_job();
  endtask

`ifdef ALIGN_SCHED_WDOG_EN
  task automatic test_watchdog();
    logic [NUM_REQ-1:0] g;
    bit ok;
    int n;
    tick();
    req_valid = 4'b0001;
    wait_grant(g);
    req_valid = '0;
    wait_start(ok);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n++;
      if (rsp_valid === 1'b1) break;
    end
    n_total++;
    if (n !== 256 || {rsp_last, rsp_error} !== 2'b11)
      $display("FAIL wdog_abort got cycles=%0d last=%b err=%b exp 256/1/1", n, rsp_last, rsp_error);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_job();
    test_trace_beats();
    test_start_holdoff();
    test_reset_mid_job();
`ifdef ALIGN_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
